// File: rtl/img_seq_ctrl.sv
// Image sequencing controller: receives NUM_IMAGES blur frames over a byte stream, runs DoG on adjacent pairs, sends results.
// Optional macro IMG_SEQ_AUTO_SEND_EN: stream every DoG result back to back without waiting for send_req.
module img_seq_ctrl #(
    parameter int DIMENSION  = 64,
    parameter int NUM_IMAGES = 2,
    localparam int PIX       = DIMENSION * DIMENSION,
    localparam int ADDR_W    = (PIX > 1) ? $clog2(PIX) : 1,
    localparam int SEL_W     = (NUM_IMAGES > 2) ? $clog2(NUM_IMAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_in_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  send_req,
    input  logic                  dog_busy,
    input  logic                  tx_busy,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [7:0]            wr_data,
    output logic [NUM_IMAGES-1:0] wr_en,
    output logic                  dog_start,
    output logic [SEL_W-1:0]      dog_sel,
    output logic                  tx_start,
    output logic [SEL_W-1:0]      tx_sel,
    output logic [SEL_W:0]        img_count,
    output logic                  overrun,
    output logic [2:0]            state_o
);

    typedef enum logic [2:0] {
        S_RECV      = 3'd0,
        S_ARM       = 3'd1,
        S_DOG_START = 3'd2,
        S_DOG_WAIT  = 3'd3,
        S_DOG_RUN   = 3'd4,
        S_READY     = 3'd5,
        S_TX_START  = 3'd6,
        S_TX_RUN    = 3'd7
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIX - 1);

    // Reset asserts asynchronously but releases two clocks later, aligned to clk.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) rst_sync_q <= 2'b00;
        else           rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     ptr_q, ptr_d;
    logic [SEL_W:0]        img_cnt_q, img_cnt_d;
    logic [SEL_W-1:0]      k_q, k_d, j_q, j_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  seen_q, seen_d;
    logic                  overrun_q, overrun_d;
    logic                  rx_prev_q;
    logic [NUM_IMAGES-1:0] wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [7:0]            wr_data_q, wr_data_d;
    logic                  dog_start_q, dog_start_d;
    logic                  tx_start_q, tx_start_d;
    logic                  rx_edge;

    assign rx_edge = rx_valid & ~rx_prev_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        img_cnt_d   = img_cnt_q;
        k_d         = k_q;
        j_d         = j_q;
        cnt_d       = cnt_q;
        seen_d      = seen_q;
        overrun_d   = overrun_q;
        wr_en_d     = '0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;

        if (rx_edge && state_q != S_RECV) overrun_d = 1'b1;

        case (state_q)
            S_RECV: begin
                if (rx_edge) begin
                    wr_en_d   = NUM_IMAGES'(1) << img_cnt_q;
                    wr_addr_d = ptr_q;
                    wr_data_d = rx_data;
                    if (ptr_q == LAST_PIX) begin
                        ptr_d     = '0;
                        img_cnt_d = img_cnt_q + 1'b1;
                        if (img_cnt_q == (SEL_W+1)'(NUM_IMAGES - 1)) begin
                            state_d = S_ARM;
                            cnt_d   = '0;
                        end
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            // Give the last BRAM write time to settle before the engine reads it.
            S_ARM: begin
                if (cnt_q == 4'd3) state_d = S_DOG_START;
                else               cnt_d   = cnt_q + 1'b1;
            end
            S_DOG_START: begin
                state_d = S_DOG_WAIT;
                cnt_d   = '0;
            end
            S_DOG_WAIT: begin
                if (dog_busy)              state_d = S_DOG_RUN;
                else if (cnt_q == 4'd15)   state_d = S_DOG_START;
                else                       cnt_d   = cnt_q + 1'b1;
            end
            S_DOG_RUN: begin
                if (!dog_busy) begin
                    if (k_q < SEL_W'(NUM_IMAGES - 2)) begin
                        k_d     = k_q + 1'b1;
                        state_d = S_DOG_START;
                    end else begin
                        state_d = S_READY;
                    end
                end
            end
            S_READY: begin
`ifdef IMG_SEQ_AUTO_SEND_EN
                state_d = S_TX_START;
`else
                if (send_req) state_d = S_TX_START;
`endif
            end
            S_TX_START: begin
                state_d = S_TX_RUN;
                seen_d  = 1'b0;
            end
            S_TX_RUN: begin
                if (tx_busy) begin
                    seen_d = 1'b1;
                end else if (seen_q) begin
                    if (j_q == SEL_W'(NUM_IMAGES - 2)) begin
                        j_d       = '0;
                        k_d       = '0;
                        img_cnt_d = '0;
                        ptr_d     = '0;
                        state_d   = S_RECV;
                    end else begin
                        j_d     = j_q + 1'b1;
                        state_d = S_READY;
                    end
                end
            end
            default: state_d = S_RECV;
        endcase

        // Start strobes coincide with the one-cycle start states.
        dog_start_d = (state_d == S_DOG_START);
        tx_start_d  = (state_d == S_TX_START);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RECV;
            ptr_q       <= '0;
            img_cnt_q   <= '0;
            k_q         <= '0;
            j_q         <= '0;
            cnt_q       <= '0;
            seen_q      <= 1'b0;
            overrun_q   <= 1'b0;
            rx_prev_q   <= 1'b0;
            wr_en_q     <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            dog_start_q <= 1'b0;
            tx_start_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            img_cnt_q   <= img_cnt_d;
            k_q         <= k_d;
            j_q         <= j_d;
            cnt_q       <= cnt_d;
            seen_q      <= seen_d;
            overrun_q   <= overrun_d;
            rx_prev_q   <= rx_valid;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            dog_start_q <= dog_start_d;
            tx_start_q  <= tx_start_d;
        end
    end

    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign wr_en     = wr_en_q;
    assign dog_start = dog_start_q;
    assign dog_sel   = k_q;
    assign tx_start  = tx_start_q;
    assign tx_sel    = j_q;
    assign img_count = img_cnt_q;
    assign overrun   = overrun_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_img_seq_ctrl.sv
// Bench for img_seq_ctrl (DIMENSION=4, NUM_IMAGES=3): writes, DoG and TX strobes are checked through an expected-event queue.
module tb_img_seq_ctrl;

    localparam int DIM = 4;
    localparam int NI  = 3;
    localparam logic [2:0] S_RECV = 3'd0, S_ARM = 3'd1, S_DOG_START = 3'd2, S_DOG_WAIT = 3'd3,
                           S_DOG_RUN = 3'd4, S_READY = 3'd5, S_TX_START = 3'd6;

    logic       clk = 1'b0;
    logic       rst_in_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       send_req = 1'b0;
    logic       dog_busy = 1'b0;
    logic       tx_busy = 1'b0;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] wr_en;
    logic       dog_start;
    logic [1:0] dog_sel;
    logic       tx_start;
    logic [1:0] tx_sel;
    logic [2:0] img_count;
    logic       overrun;
    logic [2:0] state_o;

    img_seq_ctrl #(.DIMENSION(DIM), .NUM_IMAGES(NI)) dut (
        .clk(clk), .rst_in_n(rst_in_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .send_req(send_req), .dog_busy(dog_busy), .tx_busy(tx_busy),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
        .dog_start(dog_start), .dog_sel(dog_sel), .tx_start(tx_start), .tx_sel(tx_sel),
        .img_count(img_count), .overrun(overrun), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          arm_cycles = 0;
    int          dog_cyc[$];
    logic [16:0] exp_q[$];
    logic [16:0] mon_act, mon_exp;

    // Event word: kind(0=write,1=dog_start,2=tx_start), wr_en, addr, data/sel.
    function automatic logic [16:0] ev(input logic [1:0] kind, input logic [2:0] en,
                                       input logic [3:0] addr, input logic [7:0] data);
        return {kind, en, addr, data};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every strobe the DUT presents must match the head of the expected queue.
    initial forever begin
        @(negedge clk);
        if (state_o == S_ARM) arm_cycles++;
        if (wr_en != 3'b000 || dog_start || tx_start) begin
            if (wr_en != 3'b000)  mon_act = ev(2'd0, wr_en, wr_addr, wr_data);
            else if (dog_start)   mon_act = ev(2'd1, 3'b000, 4'h0, {6'b0, dog_sel});
            else                  mon_act = ev(2'd2, 3'b000, 4'h0, {6'b0, tx_sel});
            if (dog_start) dog_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got %h, expected none", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act != mon_exp) begin
                    errors++;
                    $display("FAIL event: got %h, expected %h", mon_act, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int n = 0;
        @(negedge clk);
        while (state_o != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(state_o), int'(s));
    endtask

    task automatic send_frames();
        for (int i = 0; i < DIM * DIM * NI; i++) begin
            exp_q.push_back(ev(2'd0, 3'(1 << (i / 16)), 4'(i % 16), 8'(i)));
            send_byte(8'(i));
        end
    endtask

    // Engine model: busy for 5 cycles once a start is seen; optional send_req poke while running.
    task automatic run_dog(input bit poke_req);
        wait_state(S_DOG_START, 40, "dog_start_wait");
        tick();
        dog_busy = 1'b1;
        tick();
        tick();
        if (poke_req) send_req = 1'b1;
        tick();
        send_req = 1'b0;
        if (poke_req) check("send_req_ignored_dog_run", int'(state_o), int'(S_DOG_RUN));
        tick();
        tick();
        dog_busy = 1'b0;
    endtask

    task automatic run_tx(input bit use_req, input bit poke_rx);
        if (use_req) begin
            wait_state(S_READY, 40, "ready_wait");
            send_req = 1'b1;
            tick();
            send_req = 1'b0;
        end
        wait_state(S_TX_START, 40, "tx_start_wait");
        tick();
        tx_busy = 1'b1;
        if (poke_rx) begin
            send_byte(8'h77);
            repeat (6) tick();
        end else begin
            repeat (8) tick();
        end
        tx_busy = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, int'(state_o), 0);
        check({tag, "_img_count"}, int'(img_count), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
        check({tag, "_wr_en"}, int'(wr_en), 0);
        check({tag, "_strobes"}, int'({dog_start, tx_start}), 0);
        check({tag, "_wr_addr_data"}, int'({wr_addr, wr_data}), 0);
        check({tag, "_sels"}, int'({dog_sel, tx_sel}), 0);
    endtask

    int arm_before;

    initial begin
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_in_n = 1'b1;
        repeat (4) tick();

        // Level held for ten cycles: one write only; next byte lands at address 1.
        exp_q.push_back(ev(2'd0, 3'b001, 4'd0, 8'hA5));
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        repeat (10) tick();
        rx_valid = 1'b0;
        tick();
        exp_q.push_back(ev(2'd0, 3'b001, 4'd1, 8'h3C));
        send_byte(8'h3C);
        check("overrun_in_recv", int'(overrun), 0);

        // Abandon the partial frame.
        rst_in_n = 1'b0;
        tick();
        rst_in_n = 1'b1;
        repeat (4) tick();

        // Run 1: three frames, DoG timeout retry, two manual sends.
        arm_before = arm_cycles;
        send_frames();
        check("img_count_full", int'(img_count), 3);
        check("state_arm", int'(state_o), int'(S_ARM));
        exp_q.push_back(ev(2'd1, 3'b000, 4'h0, 8'd0));
        wait_state(S_DOG_START, 20, "first_dog_start");
        check("arm_cycles", arm_cycles - arm_before, 4);
        exp_q.push_back(ev(2'd1, 3'b000, 4'h0, 8'd0));
        exp_q.push_back(ev(2'd1, 3'b000, 4'h0, 8'd1));
        wait_state(S_DOG_WAIT, 4, "dog_wait_entry");
        run_dog(1'b0);
        run_dog(1'b1);
        wait_state(S_READY, 20, "ready_after_dog");
        check("dog_start_count", dog_cyc.size(), 3);
        if (dog_cyc.size() >= 2) check("dog_retry_interval", dog_cyc[1] - dog_cyc[0], 17);
        check("overrun_after_dog", int'(overrun), 0);
`ifndef IMG_SEQ_AUTO_SEND_EN
        repeat (5) tick();
        check("ready_holds", int'(state_o), int'(S_READY));
`endif
        exp_q.push_back(ev(2'd2, 3'b000, 4'h0, 8'd0));
        run_tx(1'b1, 1'b0);
        exp_q.push_back(ev(2'd2, 3'b000, 4'h0, 8'd1));
        run_tx(1'b1, 1'b1);
        wait_state(S_RECV, 20, "recv_after_tx");
        check("img_count_cleared", int'(img_count), 0);
        check("overrun_set_tx_run", int'(overrun), 1);

        // Run 2: reset during DoG of the second pair.
        send_frames();
        exp_q.push_back(ev(2'd1, 3'b000, 4'h0, 8'd0));
        exp_q.push_back(ev(2'd1, 3'b000, 4'h0, 8'd1));
        run_dog(1'b0);
        wait_state(S_DOG_START, 40, "second_pair_start");
        tick();
        dog_busy = 1'b1;
        tick();
        tick();
        check("in_dog_run", int'(state_o), int'(S_DOG_RUN));
        rst_in_n = 1'b0;
        #1;
        check_reset_outputs("mid_dog_reset");
        tick();
        rst_in_n = 1'b1;
        dog_busy = 1'b0;
        repeat (4) tick();

        // Run 3: full flow after the abandoned run.
        send_frames();
        exp_q.push_back(ev(2'd1, 3'b000, 4'h0, 8'd0));
        exp_q.push_back(ev(2'd1, 3'b000, 4'h0, 8'd1));
        exp_q.push_back(ev(2'd2, 3'b000, 4'h0, 8'd0));
        exp_q.push_back(ev(2'd2, 3'b000, 4'h0, 8'd1));
        run_dog(1'b0);
        run_dog(1'b0);
`ifdef IMG_SEQ_AUTO_SEND_EN
        run_tx(1'b0, 1'b0);
        run_tx(1'b0, 1'b0);
`else
        run_tx(1'b1, 1'b0);
        run_tx(1'b1, 1'b0);
`endif
        wait_state(S_RECV, 20, "recv_after_run3");
        check("img_count_run3", int'(img_count), 0);
        check("overrun_run3", int'(overrun), 0);
        repeat (3) tick();
        check("exp_q_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
